// File: rtl/cla_pipelined_adder_if.sv
// Streaming operand/result bundle for the pipelined CLA adder/subtractor.
// The producer/consumer side uses master, the adder uses slave.
interface cla_pipelined_adder_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             BP;
    logic             BG;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf, BP, BG
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf, BP, BG
    );
endinterface

// File: rtl/cla_pipelined_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SLICE-bit chunk per stage, carry registered
// between stages, valid/ready handshake with whole-pipeline stall on backpressure.
module cla_pipelined_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    cla_pipelined_adder_if.slave bus
);
    localparam int unsigned NSTAGE = WIDTH / SLICE;
    localparam int unsigned NGRP   = SLICE / 4;

    if ((WIDTH % SLICE) != 0 || (SLICE % 4) != 0 || SLICE == 0) begin : g_bad_param
        $error("cla_pipelined_adder: WIDTH must be a multiple of SLICE, SLICE a multiple of 4");
    end

    typedef struct packed {
        logic [SLICE-1:0] sum;
        logic             g;
        logic             p;
        logic             c_top;
    } slice_t;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             c;
        logic             bp;
        logic             bg;
    } stage_t;

    // Two-level lookahead: every group carry and every bit carry is a flat sum of products.
    function automatic slice_t cla_slice(input logic [SLICE-1:0] x, input logic [SLICE-1:0] y,
                                         input logic ci);
        slice_t           r;
        logic [SLICE-1:0] pb, gb, cb;
        logic [NGRP-1:0]  pg, gg, cg;
        logic             acc, pp;
        pb = x ^ y;
        gb = x & y;
        for (int j = 0; j < NGRP; j++) begin
            pg[j] = &pb[4*j +: 4];
            gg[j] = gb[4*j+3] | (pb[4*j+3] & gb[4*j+2]) | ((&pb[4*j+2 +: 2]) & gb[4*j+1])
                  | ((&pb[4*j+1 +: 3]) & gb[4*j]);
        end
        for (int j = 0; j < NGRP; j++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int i = j - 1; i >= 0; i--) begin
                acc = acc | (pp & gg[i]);
                pp  = pp & pg[i];
            end
            cg[j] = acc | (pp & ci);
        end
        for (int j = 0; j < NGRP; j++) begin
            for (int m = 0; m < 4; m++) begin
                acc = 1'b0;
                pp  = 1'b1;
                for (int i = m - 1; i >= 0; i--) begin
                    acc = acc | (pp & gb[4*j+i]);
                    pp  = pp & pb[4*j+i];
                end
                cb[4*j+m] = acc | (pp & cg[j]);
            end
        end
        r.sum   = pb ^ cb;
        r.c_top = cb[SLICE-1];
        acc = 1'b0;
        pp  = 1'b1;
        for (int i = NGRP - 1; i >= 0; i--) begin
            acc = acc | (pp & gg[i]);
            pp  = pp & pg[i];
        end
        r.g = acc;
        r.p = pp;
        return r;
    endfunction

    stage_t stage_q [NSTAGE];
    stage_t stage_d [NSTAGE];
    stage_t src     [NSTAGE];
    logic   ovf_q   [NSTAGE];
    logic   ovf_d   [NSTAGE];
    logic   stall;

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    always_comb begin
        src[0].valid = bus.in_valid;
        src[0].a     = bus.a;
        src[0].b     = bus.sub ? ~bus.b : bus.b;
        src[0].sum   = '0;
        src[0].c     = bus.cin ^ bus.sub;
        src[0].bp    = 1'b1;
        src[0].bg    = 1'b0;
        for (int k = 1; k < NSTAGE; k++) begin
            src[k] = stage_q[k-1];
        end
    end

    // bg tracks the same carry chain as c but seeded with 0, so it never sees cin.
    always_comb begin
        slice_t r;
        r = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            r = cla_slice(src[k].a[k*SLICE +: SLICE], src[k].b[k*SLICE +: SLICE], src[k].c);
            stage_d[k]                      = src[k];
            stage_d[k].sum[k*SLICE +: SLICE] = r.sum;
            stage_d[k].c                    = r.g | (r.p & src[k].c);
            stage_d[k].bg                   = r.g | (r.p & src[k].bg);
            stage_d[k].bp                   = src[k].bp & r.p;
            ovf_d[k]                        = r.c_top ^ stage_d[k].c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTAGE; k++) begin
                stage_q[k] <= '0;
                ovf_q[k]   <= 1'b0;
            end
        end else if (!stall) begin
            for (int k = 0; k < NSTAGE; k++) begin
                stage_q[k] <= stage_d[k];
                ovf_q[k]   <= ovf_d[k];
            end
        end
    end

    assign bus.out_valid = stage_q[NSTAGE-1].valid;
    assign bus.s         = stage_q[NSTAGE-1].sum;
    assign bus.cout      = stage_q[NSTAGE-1].c;
    assign bus.ovf       = ovf_q[NSTAGE-1];
    assign bus.BP        = stage_q[NSTAGE-1].bp;
    assign bus.BG        = stage_q[NSTAGE-1].bg;
endmodule

// File: tb/tb_cla_pipelined_adder.sv
// Bench for cla_pipelined_adder: a 16/4 and a 32/8 instance share one driver; results are
// checked in order against hand-computed vectors and an arithmetic reference model.
module tb_cla_pipelined_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel32;
    logic        t_valid, t_cin, t_sub, t_ready;
    logic [31:0] t_a, t_b;
    logic        o_valid, o_ready, o_cout, o_ovf, o_bp, o_bg;
    logic [31:0] o_s;

    cla_pipelined_adder_if #(.WIDTH(16)) bus16 ();
    cla_pipelined_adder_if #(.WIDTH(32)) bus32 ();

    assign bus16.in_valid  = t_valid & ~sel32;
    assign bus16.a         = t_a[15:0];
    assign bus16.b         = t_b[15:0];
    assign bus16.cin       = t_cin;
    assign bus16.sub       = t_sub;
    assign bus16.out_ready = t_ready;
    assign bus32.in_valid  = t_valid & sel32;
    assign bus32.a         = t_a;
    assign bus32.b         = t_b;
    assign bus32.cin       = t_cin;
    assign bus32.sub       = t_sub;
    assign bus32.out_ready = t_ready;

    assign o_valid = sel32 ? bus32.out_valid : bus16.out_valid;
    assign o_ready = sel32 ? bus32.in_ready  : bus16.in_ready;
    assign o_s     = sel32 ? bus32.s         : {16'h0, bus16.s};
    assign o_cout  = sel32 ? bus32.cout      : bus16.cout;
    assign o_ovf   = sel32 ? bus32.ovf       : bus16.ovf;
    assign o_bp    = sel32 ? bus32.BP        : bus16.BP;
    assign o_bg    = sel32 ? bus32.BG        : bus16.BG;

    cla_pipelined_adder #(.WIDTH(16), .SLICE(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    cla_pipelined_adder #(.WIDTH(32), .SLICE(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    typedef struct {
        logic [31:0] s;
        logic        cout, ovf, bp, bg;
        int          cyc;
    } exp_t;

    typedef struct {
        int          w;
        logic [31:0] a, b;
        logic        cin, sub;
        logic [31:0] s;
        logic        cout, ovf, bp, bg;
    } vec_t;

    localparam int NSTAGE = 4;

    exp_t        expq[$];
    exp_t        cur_exp;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pops = 0;
    logic        lat_chk, accepted, prev_stall, held_cout;
    logic [31:0] held_s;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
        exp_t            e;
        longint unsigned mask, am, be, full, nc;
        mask   = (64'd1 << w) - 64'd1;
        am     = {32'h0, a} & mask;
        be     = {32'h0, (sub ? ~b : b)} & mask;
        full   = am + be + {63'h0, cin ^ sub};
        nc     = am + be;
        e.s    = full[31:0] & mask[31:0];
        e.cout = full[w];
        e.ovf  = (am[w-1] == be[w-1]) && (full[w-1] != am[w-1]);
        e.bp   = ((am ^ be) & mask) == mask;
        e.bg   = nc[w];
        e.cyc  = 0;
        return e;
    endfunction

    function automatic vec_t mkv(int w, logic [31:0] a, logic [31:0] b, logic cin, logic sub,
                                 logic [31:0] s, logic cout, logic ovf, logic bp, logic bg);
        vec_t v;
        v.w = w; v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.s = s; v.cout = cout; v.ovf = ovf; v.bp = bp; v.bg = bg;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, req, $time);
        end
    endtask

    // Called just after the negedge with inputs set; samples, scores, then advances one cycle.
    task automatic step();
        exp_t e;
        #1;
        if (prev_stall) begin
            check("hold_valid", 32'(o_valid), 32'd1);
            check("hold_s", o_s, held_s);
            check("hold_cout", 32'(o_cout), 32'(held_cout));
        end
        if (o_valid && t_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_result: got s=%0h, required no result", o_s);
            end else begin
                e = expq.pop_front();
                pops++;
                check("s", o_s, e.s);
                check("cout", 32'(o_cout), 32'(e.cout));
                check("ovf", 32'(o_ovf), 32'(e.ovf));
                check("BP", 32'(o_bp), 32'(e.bp));
                check("BG", 32'(o_bg), 32'(e.bg));
                if (lat_chk) check("latency", 32'(cyc - e.cyc), 32'(NSTAGE));
            end
        end
        accepted = t_valid && o_ready;
        if (accepted) begin
            e     = cur_exp;
            e.cyc = cyc;
            expq.push_back(e);
        end
        prev_stall = o_valid && !t_ready;
        held_s     = o_s;
        held_cout  = o_cout;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(logic [31:0] a, logic [31:0] b, logic cin, logic sub, exp_t e);
        t_valid = 1'b1; t_a = a; t_b = b; t_cin = cin; t_sub = sub;
        cur_exp = e;
        step();
    endtask

    task automatic drain();
        int n;
        n       = 0;
        t_valid = 1'b0;
        t_ready = 1'b1;
        while (expq.size() > 0 && n < 40) begin
            step();
            n++;
        end
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d results outstanding, required 0", expq.size());
            expq.delete();
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        t_valid = 1'b0;
        t_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        prev_stall = 1'b0;
        expq.delete();
        #1;
        check("rst_out_valid", 32'(o_valid), 32'd0);
        check("rst_s", o_s, 32'd0);
        check("rst_cout", 32'(o_cout), 32'd0);
        check("rst_ovf", 32'(o_ovf), 32'd0);
        check("rst_BP", 32'(o_bp), 32'd0);
        check("rst_BG", 32'(o_bg), 32'd0);
        check("rst_in_ready", 32'(o_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[13];
        exp_t        e;
        logic [31:0] op_a[8], op_b[8];
        logic        op_c[8], op_s[8];
        int          sent, pops0;

        rst_n = 1'b0; sel32 = 1'b0; t_valid = 1'b0; t_a = '0; t_b = '0;
        t_cin = 1'b0; t_sub = 1'b0; t_ready = 1'b1; lat_chk = 1'b1;
        prev_stall = 1'b0; accepted = 1'b0; held_s = '0; held_cout = 1'b0;

        tbl[0]  = mkv(16, 32'd1060,     32'd11000,    1'b0, 1'b0, 32'd12060,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mkv(16, 32'd12500,    32'd3100,     1'b1, 1'b0, 32'd15601,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mkv(16, 32'd30143,    32'd2200,     1'b0, 1'b0, 32'd32343,  1'b0, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mkv(16, 32'd65505,    32'd31,       1'b0, 1'b0, 32'd0,      1'b1, 1'b0, 1'b0, 1'b1);
        tbl[4]  = mkv(16, 32'd32005,    32'd33533,    1'b0, 1'b0, 32'd2,      1'b1, 1'b0, 1'b0, 1'b1);
        tbl[5]  = mkv(16, 32'd30000,    32'd5000,     1'b0, 1'b0, 32'd35000,  1'b0, 1'b1, 1'b0, 1'b0);
        tbl[6]  = mkv(16, 32'h00FF,     32'hFF00,     1'b0, 1'b0, 32'hFFFF,   1'b0, 1'b0, 1'b1, 1'b0);
        tbl[7]  = mkv(16, 32'h00FF,     32'hFF00,     1'b1, 1'b0, 32'd0,      1'b1, 1'b0, 1'b1, 1'b0);
        tbl[8]  = mkv(16, 32'h8000,     32'h8000,     1'b0, 1'b0, 32'd0,      1'b1, 1'b1, 1'b0, 1'b1);
        tbl[9]  = mkv(16, 32'd1000,     32'd1001,     1'b0, 1'b1, 32'hFFFF,   1'b0, 1'b0, 1'b0, 1'b0);
        tbl[10] = mkv(16, 32'd5000,     32'd3000,     1'b0, 1'b1, 32'd2000,   1'b1, 1'b0, 1'b0, 1'b1);
        tbl[11] = mkv(16, 32'd10,       32'd3,        1'b1, 1'b1, 32'd6,      1'b1, 1'b0, 1'b0, 1'b1);
        tbl[12] = mkv(32, 32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 32'd0,      1'b1, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        do_reset();

        // Directed vectors, back-to-back with fixed latency.
        for (int i = 0; i < 13; i++) begin
            if ((tbl[i].w == 32) != sel32) begin
                drain();
                sel32 = (tbl[i].w == 32);
            end
            e.s = tbl[i].s; e.cout = tbl[i].cout; e.ovf = tbl[i].ovf;
            e.bp = tbl[i].bp; e.bg = tbl[i].bg; e.cyc = 0;
            drive(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, e);
        end
        drain();

        // Eight ops on the 32-bit unit with three cycles of backpressure mid-stream.
        sel32   = 1'b1;
        lat_chk = 1'b0;
        for (int i = 0; i < 8; i++) begin
            op_a[i] = $urandom; op_b[i] = $urandom;
            op_c[i] = 1'($urandom_range(0, 1)); op_s[i] = 1'($urandom_range(0, 1));
        end
        op_a[3] = 32'hFFFFFFFF; op_b[3] = 32'd1; op_c[3] = 1'b0; op_s[3] = 1'b0;
        sent  = 0;
        pops0 = pops;
        for (int c = 0; c < 40 && sent < 8; c++) begin
            t_ready = !(c >= 6 && c < 9);
            t_valid = 1'b1;
            t_a = op_a[sent]; t_b = op_b[sent]; t_cin = op_c[sent]; t_sub = op_s[sent];
            cur_exp = model(32, op_a[sent], op_b[sent], op_c[sent], op_s[sent]);
            if (!t_ready) begin
                #1;
                check("stall_out_valid", 32'(o_valid), 32'd1);
                check("stall_in_ready", 32'(o_ready), 32'd0);
            end
            step();
            if (accepted) sent++;
        end
        drain();
        check("stall_result_count", 32'(pops - pops0), 32'd8);

        // Reset with three ops in flight; none may surface afterwards.
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, 1'b0, 1'b0, model(32, 32'd1, 32'd1, 1'b0, 1'b0));
        end
        do_reset();
        t_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("post_rst_idle", 32'(o_valid), 32'd0);
            step();
        end
        e.s = 32'd15; e.cout = 1'b0; e.ovf = 1'b0; e.bp = 1'b0; e.bg = 1'b0; e.cyc = 0;
        drive(32'd7, 32'd8, 1'b0, 1'b0, e);
        drain();

        // Random traffic with random bubbles and backpressure on both widths.
        lat_chk = 1'b0;
        for (int w = 0; w < 2; w++) begin
            sel32 = (w == 1);
            for (int i = 0; i < 300; i++) begin
                t_valid = ($urandom_range(0, 3) != 0);
                t_ready = ($urandom_range(0, 3) != 0);
                t_a = $urandom; t_b = $urandom;
                t_cin = 1'($urandom_range(0, 1)); t_sub = 1'($urandom_range(0, 1));
                cur_exp = model(sel32 ? 32 : 16, t_a, t_b, t_cin, t_sub);
                step();
            end
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
